// File: rtl/ddr_rd_port_arbiter.sv
// Round-robin arbiter sharing one DDR read engine between two read ports.
// Optional watchdog in WAIT_DONE: define DDR_RD_ARB_TIMEOUT_EN.
module ddr_rd_port_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_DDR_LOCAL_QUEUE  = 3,
  parameter int P_TIMEOUT_CYCLES   = 65535
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_port0_rd_flag,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_port0_rd_queue,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_port0_rd_byte,
  input  logic                          i_port0_rd_byte_valid,
  output logic                          o_port0_rd_byte_ready,
  output logic                          o_port0_rd_queue_finish,
  input  logic                          i_port1_rd_flag,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_port1_rd_queue,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_port1_rd_byte,
  input  logic                          i_port1_rd_byte_valid,
  output logic                          o_port1_rd_byte_ready,
  output logic                          o_port1_rd_queue_finish,
  output logic [P_DDR_LOCAL_QUEUE-1:0]  o_ddr_rd_queue,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] o_ddr_rd_byte,
  output logic                          o_ddr_rd_port,
  output logic                          o_ddr_rd_valid,
  input  logic                          i_ddr_rd_ready,
  input  logic                          i_ddr_rd_finish,
  output logic                          o_busy,
  output logic                          o_timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic                          last_grant;
  logic [P_DDR_LOCAL_QUEUE-1:0]  cmd_queue;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_byte;
  logic                          cmd_port;

  logic                          elig0;
  logic                          elig1;
  logic                          win0;
  logic                          win1;
  logic                          idle;
  logic                          grant;
  logic [P_DDR_LOCAL_QUEUE-1:0]  grant_queue;
  logic [C_M_AXI_ADDR_WIDTH-1:0] grant_byte;
  logic                          tmo;

  assign elig0 = i_port0_rd_flag & i_port0_rd_byte_valid;
  assign elig1 = i_port1_rd_flag & i_port1_rd_byte_valid;

  // On contention the port that did not win last time goes first
  assign win0 = elig0 & (~elig1 | last_grant);
  assign win1 = elig1 & (~elig0 | ~last_grant);

  assign idle        = (state == IDLE) & i_rst;
  assign grant       = idle & (win0 | win1);
  assign grant_queue = win1 ? i_port1_rd_queue : i_port0_rd_queue;
  assign grant_byte  = win1 ? i_port1_rd_byte : i_port0_rd_byte;

`ifdef DDR_RD_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT_DONE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  assign tmo = (state == WAIT_DONE) & ~i_ddr_rd_finish &
               (wait_cnt == 32'(P_TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_nx = (grant_byte != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (i_ddr_rd_ready) begin
          state_nx = i_ddr_rd_finish ? DONE : WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_ddr_rd_finish | tmo) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_grant <= 1'b1;
      cmd_queue  <= '0;
      cmd_byte   <= '0;
      cmd_port   <= 1'b0;
    end else if (grant) begin
      last_grant <= win1;
      cmd_queue  <= grant_queue;
      cmd_byte   <= grant_byte;
      cmd_port   <= win1;
    end
  end

  always_comb begin
    o_port0_rd_byte_ready   = idle & win0;
    o_port1_rd_byte_ready   = idle & win1;
    o_port0_rd_queue_finish = (state == DONE) & ~cmd_port;
    o_port1_rd_queue_finish = (state == DONE) & cmd_port;
    o_ddr_rd_valid          = (state == ISSUE);
    o_ddr_rd_queue          = cmd_queue;
    o_ddr_rd_byte           = cmd_byte;
    o_ddr_rd_port           = cmd_port;
    o_busy                  = (state != IDLE);
    o_timeout_err           = tmo;
  end

endmodule

// File: tb/tb_ddr_rd_port_arbiter.sv
// Bench for ddr_rd_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_ddr_rd_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f0, v0, f1, v1;
  logic [2:0]  q0, q1;
  logic [31:0] b0, b1;
  logic        e_rdy, e_fin;
  logic        rdy0, rdy1, fin0, fin1;
  logic [2:0]  d_q;
  logic [31:0] d_b;
  logic        d_p, d_v, busy, terr;

  int checks = 0;
  int errors = 0;

  // transaction-level model
  bit        m_act, m_own, m_sent, m_fin, m_last;
  bit [2:0]  m_q;
  bit [31:0] m_b;

  always #5 clk = ~clk;

  ddr_rd_port_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_port0_rd_flag(f0), .i_port0_rd_queue(q0),
    .i_port0_rd_byte(b0), .i_port0_rd_byte_valid(v0),
    .o_port0_rd_byte_ready(rdy0), .o_port0_rd_queue_finish(fin0),
    .i_port1_rd_flag(f1), .i_port1_rd_queue(q1),
    .i_port1_rd_byte(b1), .i_port1_rd_byte_valid(v1),
    .o_port1_rd_byte_ready(rdy1), .o_port1_rd_queue_finish(fin1),
    .o_ddr_rd_queue(d_q), .o_ddr_rd_byte(d_b),
    .o_ddr_rd_port(d_p), .o_ddr_rd_valid(d_v),
    .i_ddr_rd_ready(e_rdy), .i_ddr_rd_finish(e_fin),
    .o_busy(busy), .o_timeout_err(terr)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_own = 0; m_sent = 0; m_fin = 0;
    m_last = 1; m_q = 0; m_b = 0;
  endtask

  task automatic idle_in();
    f0 = 0; v0 = 0; q0 = 0; b0 = 0;
    f1 = 0; v1 = 0; q1 = 0; b1 = 0;
    e_rdy = 0; e_fin = 0;
  endtask

  // One clock: compare outputs, advance model on the edge
  task automatic cyc();
    bit el0, el1, x0, x1, hs;
    #1;
    if (!rst) m_reset();
    el0 = f0 & v0;
    el1 = f1 & v1;
    x0 = 0; x1 = 0;
    if (rst && !m_act) begin
      if (el0 && el1) begin
        x0 = m_last; x1 = !m_last;
      end else begin
        x0 = el0; x1 = el1;
      end
    end
    chk("ready0", rdy0, x0);
    chk("ready1", rdy1, x1);
    chk("finish0", fin0, m_act && m_fin && !m_own);
    chk("finish1", fin1, m_act && m_fin && m_own);
    chk("ddr_valid", d_v, m_act && !m_fin && !m_sent);
    chk("ddr_queue", d_q, m_q);
    chk("ddr_byte", d_b, m_b);
    chk("ddr_port", d_p, m_own);
    chk("busy", busy, m_act);
    chk("timeout_err", terr, 0);
    @(posedge clk);
    hs = x0 | x1;
    if (!rst) begin
      m_reset();
    end else if (!m_act) begin
      if (hs) begin
        m_act = 1;
        m_own = x1;
        m_last = x1;
        m_q = x1 ? q1 : q0;
        m_b = x1 ? b1 : b0;
        m_sent = 0;
        m_fin = (m_b == 0);
      end
    end else if (m_fin) begin
      m_act = 0;
      m_fin = 0;
    end else if (!m_sent) begin
      if (e_rdy) begin
        m_sent = 1;
        m_fin = e_fin;
      end
    end else if (e_fin) begin
      m_fin = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    idle_in();
    cyc();
    cyc();
    rst = 1;
  endtask

  initial begin
    int grants[$];
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    m_reset();
    idle_in();
    rst = 0;
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", d_v, 0);
    chk("rst_byte", d_b, 0);
    do_reset();

    // port0 single read, engine finishes 10 cycles after accept
    f0 = 1; v0 = 1; q0 = 3; b0 = 32'h400; e_rdy = 1;
    #1;
    chk("s1_ready0", rdy0, 1);
    cyc();
    v0 = 0;
    #1;
    chk("s1_valid", d_v, 1);
    chk("s1_queue", d_q, 3);
    chk("s1_byte", d_b, 32'h400);
    chk("s1_port", d_p, 0);
    cyc();
    for (int i = 0; i < 9; i++) cyc();
    e_fin = 1;
    cyc();
    e_fin = 0;
    #1;
    chk("s1_fin0", fin0, 1);
    chk("s1_fin1", fin1, 0);
    cyc();
    cyc();

    // contention from reset alternates grants
    do_reset();
    f0 = 1; v0 = 1; q0 = 1; b0 = 32'h10;
    f1 = 1; v1 = 1; q1 = 2; b1 = 32'h20;
    e_rdy = 1; e_fin = 1;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (rdy0) grants.push_back(0);
      if (rdy1) grants.push_back(1);
      cyc();
    end
    chk("s2_count", grants.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk("s2_grant", i < grants.size() ? grants[i] : 9, exp_g[i]);

    // zero-length request on port1
    do_reset();
    f1 = 1; v1 = 1; q1 = 5; b1 = 0;
    #1;
    chk("s3_ready1", rdy1, 1);
    cyc();
    v1 = 0;
    #1;
    chk("s3_novalid", d_v, 0);
    chk("s3_fin1", fin1, 1);
    cyc();
    #1;
    chk("s3_idle", busy, 0);
    cyc();

    // engine stalls with both ports requesting
    f0 = 1; v0 = 1; q0 = 6; b0 = 32'hABC; e_rdy = 0;
    cyc();
    f1 = 1; v1 = 1; q1 = 2; b1 = 32'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s4_valid", d_v, 1);
      chk("s4_byte", d_b, 32'hABC);
      chk("s4_rdy", {rdy0, rdy1}, 0);
      cyc();
    end
    idle_in();
    e_rdy = 1;
    cyc();

    // reset while waiting for engine completion
    for (int i = 0; i < 4; i++) cyc();
    f0 = 1; v0 = 1; q0 = 4; b0 = 32'h80; e_rdy = 1;
    cyc();
    v0 = 0;
    cyc();
    cyc();
    #1;
    chk("s5_waiting", busy, 1);
    rst = 0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_byte", d_b, 0);
    chk("s5_fin", {fin0, fin1}, 0);
    cyc();
    rst = 1;
    f0 = 1; v0 = 1; f1 = 1; v1 = 1; b1 = 32'h9;
    #1;
    chk("s5_first", {rdy0, rdy1}, 2'b10);
    cyc();
    idle_in();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      f0 = ($urandom_range(0, 7) != 0);
      v0 = ($urandom_range(0, 2) != 0);
      q0 = 3'($urandom);
      b0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      f1 = ($urandom_range(0, 7) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      q1 = 3'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      e_rdy = $urandom_range(0, 1);
      e_fin = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst = 1;
    idle_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
